// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, WIDTH+2 cycle latency.
// Optional feature macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow finish at accept.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             div_sel_div,
  input  logic             div_sel_divu,
  input  logic             div_sel_rem,
  input  logic             div_sel_remu,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    CNT_LOAD = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2
  } state_t;

  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
    return ~x + ONE_W;
  endfunction

  state_t           state_r;
  logic [WIDTH-1:0] rem_r, quo_r, div_r;
  logic [CW-1:0]    count_r;
  logic             sign_a_r, sign_b_r, dbz_r, is_rem_r;

  logic             op_signed_s, op_rem_s, dbz_s;
  logic [WIDTH-1:0] abs_a_s, abs_b_s;
  logic             early_take_s;
  logic [WIDTH-1:0] early_val_s;
  logic [WIDTH:0]   shifted_s, trial_s;
  logic             ge_s;
  logic [WIDTH-1:0] rem_next_s, quo_next_s, final_s;

  // DIV has priority, then REM, then REMU; no select at all behaves as DIVU.
  assign op_signed_s = div_sel_div | div_sel_rem;
  assign op_rem_s    = ~div_sel_div & (div_sel_rem | div_sel_remu);
  assign dbz_s       = (operand_b == ZERO_W);
  assign abs_a_s     = (op_signed_s && operand_a[WIDTH-1]) ? neg(operand_a) : operand_a;
  assign abs_b_s     = (op_signed_s && operand_b[WIDTH-1]) ? neg(operand_b) : operand_b;

`ifdef DIV_EARLY_OUT_EN
  logic ovf_s;
  assign ovf_s = op_signed_s && (operand_a == {1'b1, {(WIDTH-1){1'b0}}}) && (operand_b == ONES_W);
  assign early_take_s = dbz_s | ovf_s;
  assign early_val_s  = dbz_s ? (op_rem_s ? operand_a : ONES_W)
                              : (op_rem_s ? ZERO_W : operand_a);
`else
  assign early_take_s = 1'b0;
  assign early_val_s  = ZERO_W;
`endif

  // One restoring step: a set shifted-out bit or a clear borrow bit means the trial fits.
  always_comb begin
    shifted_s  = {rem_r, quo_r[WIDTH-1]};
    trial_s    = shifted_s - {1'b0, div_r};
    ge_s       = shifted_s[WIDTH] | ~trial_s[WIDTH];
    quo_next_s = {quo_r[WIDTH-2:0], ge_s};
    if (ge_s) begin
      rem_next_s = trial_s[WIDTH-1:0];
    end else begin
      rem_next_s = shifted_s[WIDTH-1:0];
    end
  end

  // Sign fix-up; the quotient of a divide-by-zero keeps its all-ones value.
  always_comb begin
    final_s = quo_r;
    if (is_rem_r) begin
      if (sign_a_r) begin
        final_s = neg(rem_r);
      end else begin
        final_s = rem_r;
      end
    end else begin
      if ((sign_a_r ^ sign_b_r) && !dbz_r) begin
        final_s = neg(quo_r);
      end else begin
        final_s = quo_r;
      end
    end
  end

  // Control FSM and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= ZERO_W;
      zero_flag <= 1'b1;
      count_r   <= {CW{1'b0}};
      rem_r     <= ZERO_W;
      quo_r     <= ZERO_W;
      div_r     <= ZERO_W;
      sign_a_r  <= 1'b0;
      sign_b_r  <= 1'b0;
      dbz_r     <= 1'b0;
      is_rem_r  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start && !flush) begin
            if (early_take_s) begin
              result    <= early_val_s;
              zero_flag <= (early_val_s == ZERO_W);
              done      <= 1'b1;
            end else begin
              quo_r    <= abs_a_s;
              div_r    <= abs_b_s;
              rem_r    <= ZERO_W;
              count_r  <= CNT_LOAD;
              sign_a_r <= op_signed_s & operand_a[WIDTH-1];
              sign_b_r <= op_signed_s & operand_b[WIDTH-1];
              dbz_r    <= dbz_s;
              is_rem_r <= op_rem_s;
              busy     <= 1'b1;
              state_r  <= CALC;
            end
          end
        end
        CALC: begin
          if (flush) begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end else begin
            rem_r <= rem_next_s;
            quo_r <= quo_next_s;
            if (count_r == {CW{1'b0}}) begin
              state_r <= SIGN;
            end else begin
              count_r <= count_r - CNT_ONE;
            end
          end
        end
        SIGN: begin
          if (!flush) begin
            result    <= final_s;
            zero_flag <= (final_s == ZERO_W);
            done      <= 1'b1;
          end
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: scoreboard of expected results, latency and busy/done timing.
// Honours DIV_EARLY_OUT_EN when the design is built with it.
module tb_div_unit;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic         clk = 1'b0;
  logic         rst, start, flush;
  logic [W-1:0] a, b;
  logic         sd, sdu, sr, sru;
  logic         busy, done, zero_flag;
  logic [W-1:0] result;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] res;
    int           lat;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] prev_res;

  div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush),
    .operand_a(a), .operand_b(b),
    .div_sel_div(sd), .div_sel_divu(sdu), .div_sel_rem(sr), .div_sel_remu(sru),
    .busy(busy), .done(done), .result(result), .zero_flag(zero_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // Behavioural reference; op: 0 DIV, 1 DIVU, 2 REM, 3 REMU, 4 no select (DIVU).
  function automatic logic [W-1:0] ref_model(input int op, input logic [W-1:0] x, input logic [W-1:0] y);
    logic         ovf;
    logic [W-1:0] r;
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    if (op == 0) begin
      if (y == 32'd0)  r = 32'hFFFF_FFFF;
      else if (ovf)    r = x;
      else             r = $signed(x) / $signed(y);
    end else if (op == 2) begin
      if (y == 32'd0)  r = x;
      else if (ovf)    r = 32'd0;
      else             r = $signed(x) % $signed(y);
    end else if (op == 3) begin
      if (y == 32'd0)  r = x;
      else             r = x % y;
    end else begin
      if (y == 32'd0)  r = 32'hFFFF_FFFF;
      else             r = x / y;
    end
    return r;
  endfunction

  function automatic int exp_lat(input int op, input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef DIV_EARLY_OUT_EN
    if (y == 32'd0) return 1;
    if ((op == 0 || op == 2) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
    return LAT;
`else
    return LAT;
`endif
  endfunction

  task automatic set_sel(input int op);
    sd = 1'b0; sdu = 1'b0; sr = 1'b0; sru = 1'b0;
    case (op)
      0: sd  = 1'b1;
      1: sdu = 1'b1;
      2: sr  = 1'b1;
      3: sru = 1'b1;
      default: ;
    endcase
  endtask

  // Drive one start (caller sits just after a negedge) and push its expectation.
  task automatic launch(input int op, input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] expv);
    exp_t e;
    e.res = expv;
    e.lat = exp_lat(op, x, y);
    sb.push_back(e);
    a = x; b = y; set_sel(op);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    set_sel(5);
    a = $urandom;
    b = $urandom;
  endtask

  // Wait for done, pop the expectation and compare; optionally pulse a stray start.
  task automatic wait_done(input int ign_at);
    exp_t e;
    bit   got;
    got = 1'b0;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    for (int lat = 1; lat <= LAT + 6; lat++) begin
      @(negedge clk);
      if (lat == 1) begin
        check("busy_c1", 32'(busy), (e.lat == 1) ? 32'd0 : 32'd1);
        if (e.lat != 1) check("done_c1", 32'(done), 32'd0);
      end
      if (ign_at > 0 && lat == ign_at) begin
        a = 32'd9; b = 32'd3; set_sel(1); start = 1'b1;
      end
      if (ign_at > 0 && lat == ign_at + 1) begin
        start = 1'b0; set_sel(5);
      end
      if (e.lat == LAT && lat == LAT - 1) begin
        check("busy_last", 32'(busy), 32'd1);
        check("result_held", result, prev_res);
      end
      if (done) begin
        got = 1'b1;
        check("latency", 32'(lat), 32'(e.lat));
        check("result", result, e.res);
        check("zero_flag", 32'(zero_flag), (e.res == 32'd0) ? 32'd1 : 32'd0);
        check("busy_done", 32'(busy), 32'd0);
        prev_res = e.res;
        break;
      end
    end
    if (!got) check("timeout", 32'd0, 32'd1);
  endtask

  task automatic run(input int op, input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] expv);
    launch(op, x, y, expv);
    wait_done(0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dcount;
    int bcount;
    logic [W-1:0] x, y;
    int op;
    rst = 1'b1; start = 1'b0; flush = 1'b0; a = '0; b = '0; set_sel(5);
    prev_res = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zf", 32'(zero_flag), 32'd1);

    // Directed cases, issued back-to-back in each done cycle.
    run(0, 32'd100, 32'd7, 32'd14);
    run(2, 32'd100, 32'd7, 32'd2);
    run(0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run(2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run(1, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC);
    run(0, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF);
    run(3, 32'h0000_1234, 32'd0, 32'h0000_1234);
    run(2, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);
    run(0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run(2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run(4, 32'd77, 32'd7, 32'd11);
    run(3, 32'd5, 32'd9, 32'd5);
    run(1, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);

    // Stray start at cycle 10 must be ignored.
    launch(1, 32'd50, 32'd5, 32'd10);
    wait_done(10);
    run(0, 32'd21, 32'hFFFF_FFFD, 32'hFFFF_FFF9);

    for (int i = 0; i < 8; i++) begin
      op = $urandom_range(0, 3);
      x  = $urandom;
      y  = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if (i == 4) y = 32'd0;
      run(op, x, y, ref_model(op, x, y));
    end

    // Flush at cycle 15: no done, result kept.
    a = 32'd1000; b = 32'd3; set_sel(1); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; set_sel(5);
    repeat (15) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_result", result, prev_res);
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("flush_no_done", 32'(dcount), 32'd0);
    check("flush_result_late", result, prev_res);

    // Flush together with start in IDLE launches nothing.
    a = 32'd8; b = 32'd2; set_sel(1); start = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0; set_sel(5);
    dcount = 0; bcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcount++;
      if (busy) bcount++;
    end
    check("flush_start_done", 32'(dcount), 32'd0);
    check("flush_start_busy", 32'(bcount), 32'd0);

    // Reset in cycle 20 of an operation.
    a = 32'd1000; b = 32'd7; set_sel(0); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; set_sel(5);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_result", result, 32'd0);
    check("mid_rst_zf", 32'(zero_flag), 32'd1);
    prev_res = 32'd0;
    run(0, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
